// File: rtl/sensors_height_filter.sv
// sensors_height_filter
//   Averages N_PAIRS pairs of opposing distance sensors into one rounded
//   height per accepted sample. A pair is excluded when either lane reads
//   zero or has a latched fault. A lane that reads zero for FAULT_LIMIT
//   consecutive samples latches a sticky fault flag.
//   Fixed latency: N_PAIRS accumulate cycles plus SUMW divide cycles.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   sensors      packed lanes, lane i at [i*WIDTH +: WIDTH]
//   in_valid     sample present       in_ready   accepting (IDLE only)
//   fault_clr    sync clear of lane faults and zero counters
//   height       rounded average      pairs_used pairs in the average
//   out_valid    result valid         out_ready  consumer accepts result
//   lane_fault   sticky per-lane fault flags
module sensors_height_filter #(
  parameter int WIDTH       = 8,
  parameter int N_PAIRS     = 2,
  parameter int FAULT_LIMIT = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [2*N_PAIRS*WIDTH-1:0]     sensors,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           fault_clr,
  output logic [WIDTH-1:0]               height,
  output logic [$clog2(N_PAIRS+1)-1:0]   pairs_used,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*N_PAIRS-1:0]           lane_fault
);

  localparam int LANES = 2 * N_PAIRS;
  localparam int SUMW  = WIDTH + $clog2(2 * N_PAIRS);
  localparam int PW    = $clog2(N_PAIRS + 1);
  localparam int CMAX  = (SUMW > N_PAIRS) ? SUMW : N_PAIRS;
  localparam int CW    = $clog2(CMAX + 1);
  localparam logic [3:0] FL = 4'(FAULT_LIMIT);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t                   state, state_nxt;
  logic [LANES*WIDTH-1:0]   snap;
  logic [N_PAIRS-1:0]       qual, qual_nxt;
  logic [SUMW-1:0]          sum, sum_n, dvd;
  logic [PW-1:0]            k, k_n;
  logic [SUMW-1:0]          rem, rem_n;
  logic [WIDTH-1:0]         quo, quo_n;
  logic [CW-1:0]            cnt;
  logic [LANES-1:0][3:0]    zcnt, zcnt_nxt;
  logic [LANES-1:0]         fault_nxt;
  logic                     accept, accum_last, div_last, qbit;
  logic [SUMW:0]            shifted, dsor;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && (state == IDLE);
  assign accum_last = (cnt == CW'(N_PAIRS - 1));
  assign div_last   = (cnt == CW'(SUMW - 1));

  // Zero counters / faults: a coincident clear is applied before the
  // sample's own update. Pair qualification is captured at accept so a
  // later fault_clr cannot alter an in-flight sample.
  always_comb begin
    zcnt_nxt  = zcnt;
    fault_nxt = lane_fault;
    qual_nxt  = '0;
    if (fault_clr) begin
      zcnt_nxt  = '0;
      fault_nxt = '0;
    end
    if (accept) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (sensors[i*WIDTH +: WIDTH] == '0) begin
          if (zcnt_nxt[i] != FL) zcnt_nxt[i] = zcnt_nxt[i] + 4'd1;
        end else begin
          zcnt_nxt[i] = '0;
        end
        if (zcnt_nxt[i] == FL) fault_nxt[i] = 1'b1;
      end
      for (int unsigned p = 0; p < N_PAIRS; p++) begin
        qual_nxt[p] = (sensors[(2*p)*WIDTH +: WIDTH] != '0) &&
                      (sensors[(2*p+1)*WIDTH +: WIDTH] != '0) &&
                      !fault_nxt[2*p] && !fault_nxt[2*p+1];
      end
    end
  end

  // Accumulate always consumes the lowest pair of the snapshot; the
  // snapshot and qualify mask are shifted down one pair per cycle.
  always_comb begin
    sum_n = sum;
    k_n   = k;
    if (qual[0]) begin
      sum_n = sum + SUMW'(snap[WIDTH-1:0]) + SUMW'(snap[2*WIDTH-1:WIDTH]);
      k_n   = k + PW'(1);
    end
  end

  // Restoring divider step; divisor is 2k.
  always_comb begin
    dsor    = (SUMW+1)'({k, 1'b0});
    shifted = {rem, dvd[SUMW-1]};
    qbit    = (shifted >= dsor);
    rem_n   = qbit ? SUMW'(shifted - dsor) : SUMW'(shifted);
    quo_n   = WIDTH'({quo, qbit});
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCUM;
      ACCUM:   if (accum_last) state_nxt = DIVIDE;
      DIVIDE:  if (div_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      snap       <= '0;
      qual       <= '0;
      sum        <= '0;
      k          <= '0;
      dvd        <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      zcnt       <= '0;
      lane_fault <= '0;
      height     <= '0;
      pairs_used <= '0;
    end else begin
      state      <= state_nxt;
      zcnt       <= zcnt_nxt;
      lane_fault <= fault_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            snap <= sensors;
            qual <= qual_nxt;
            sum  <= '0;
            k    <= '0;
            cnt  <= '0;
          end
        end
        ACCUM: begin
          snap <= snap >> (2 * WIDTH);
          qual <= qual >> 1;
          sum  <= sum_n;
          k    <= k_n;
          if (accum_last) begin
            cnt <= '0;
            dvd <= sum_n + SUMW'(k_n);
            rem <= '0;
            quo <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DIVIDE: begin
          dvd <= dvd << 1;
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + CW'(1);
          if (div_last) begin
            height     <= (k == '0) ? '0 : quo_n;
            pairs_used <= k;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensors_height_filter.sv
module tb_sensors_height_filter;
  localparam int W   = 8;
  localparam int N   = 2;
  localparam int L   = 2 * N;
  localparam int FL  = 3;
  localparam int LAT = N + W + $clog2(2 * N);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [L*W-1:0] sensors = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           fault_clr = 1'b0;
  logic [W-1:0]   height;
  logic [1:0]     pairs_used;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [L-1:0]   lane_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sensors_height_filter #(.WIDTH(W), .N_PAIRS(N), .FAULT_LIMIT(FL)) dut (
    .clk(clk), .rst_n(rst_n), .sensors(sensors), .in_valid(in_valid),
    .in_ready(in_ready), .fault_clr(fault_clr), .height(height),
    .pairs_used(pairs_used), .out_valid(out_valid), .out_ready(out_ready),
    .lane_fault(lane_fault)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Behavioural reference: sample-level arithmetic plus a latency timer.
  int         mcnt [L];
  logic [L-1:0] mfault;
  bit         m_busy, m_done;
  int         m_timer, m_h, m_p, ms, mk, ma, mb, mv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) mcnt[i] = 0;
      mfault = '0; m_busy = 0; m_done = 0; m_timer = 0; m_h = 0; m_p = 0;
    end else begin
      bit acc;
      acc = in_valid && !m_busy;
      if (fault_clr) begin
        for (int i = 0; i < L; i++) mcnt[i] = 0;
        mfault = '0;
      end
      if (acc) begin
        for (int i = 0; i < L; i++) begin
          mv = int'(sensors[i*W +: W]);
          if (mv == 0) mcnt[i] = (mcnt[i] < FL) ? mcnt[i] + 1 : FL;
          else mcnt[i] = 0;
          if (mcnt[i] == FL) mfault[i] = 1'b1;
        end
        ms = 0; mk = 0;
        for (int p = 0; p < N; p++) begin
          ma = int'(sensors[(2*p)*W +: W]);
          mb = int'(sensors[(2*p+1)*W +: W]);
          if (ma != 0 && mb != 0 && !mfault[2*p] && !mfault[2*p+1]) begin
            ms += ma + mb;
            mk++;
          end
        end
        m_h = (mk != 0) ? (ms + mk) / (2 * mk) : 0;
        m_p = mk;
        m_busy = 1; m_done = 0; m_timer = 0;
      end else if (m_busy && !m_done) begin
        m_timer++;
        if (m_timer == LAT) m_done = 1;
      end else if (m_done && out_ready) begin
        m_busy = 0; m_done = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("in_ready", in_ready, !m_busy);
    chk("out_valid", out_valid, m_done);
    chk("lane_fault", lane_fault, mfault);
    if (m_done) begin
      chk("height", height, m_h);
      chk("pairs_used", pairs_used, m_p);
    end
  end

  task automatic send(input logic [31:0] s);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    sensors = s;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int eh, input int ep);
    int cyc;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_latency"}, cyc, 12);
    chk({nm, "_height"}, height, eh);
    chk({nm, "_pairs"}, pairs_used, ep);
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_height", height, 0);
    chk("rst_pairs", pairs_used, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_lane_fault", lane_fault, 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(pk(100, 102, 98, 101));  wait_result("avg4", 100, 2);
    send(pk(80, 0, 50, 51));      wait_result("one_pair", 51, 1);
    chk("no_fault", lane_fault, 0);
    send(pk(0, 0, 0, 0));         wait_result("all_zero", 0, 0);
    send(pk(255, 255, 255, 255)); wait_result("all_max", 255, 2);

    for (int i = 0; i < 3; i++) begin
      send(pk(10, 10, 10, 0));    wait_result("lane3_zero", 10, 1);
    end
    chk("lane3_fault", lane_fault, 4'b1000);
    send(pk(100, 100, 200, 200)); wait_result("faulted", 100, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    chk("fault_cleared", lane_fault, 0);
    send(pk(100, 100, 200, 200)); wait_result("cleared", 150, 2);

    out_ready = 1'b0;
    send(pk(20, 22, 30, 30));     wait_result("hold", 26, 2);
    for (int i = 0; i < 5; i++) begin
      sensors = pk(1, 1, 1, 1);
      in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_height", height, 26);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);

    for (int i = 0; i < 3; i++) begin
      send(pk(0, 5, 5, 5));       wait_result("lane0_zero", 5, 1);
    end
    chk("lane0_fault", lane_fault, 4'b0001);
    send(pk(100, 102, 98, 101));
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_lane_fault", lane_fault, 0);
    chk("midrst_height", height, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(pk(100, 102, 98, 101));  wait_result("after_rst", 100, 2);

    for (int c = 0; c < 1500; c++) begin
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < L; i++)
        s[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      sensors   = s;
      in_valid  = ($urandom_range(0, 3) == 0);
      fault_clr = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    fault_clr = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("drained", in_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensors_height_filter.md
# sensors_height_filter

Parametrised, sequential successor to the combinational sensor-height stage: averages N_PAIRS pairs of opposing distance sensors into one rounded height per sample. Pairs with a zero reading or a latched faulty lane are excluded; lanes reading zero for FAULT_LIMIT consecutive samples are flagged. Sits between the sensor sampling logic and the baggage classification FSM, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 8, bits per sensor reading and of height
- N_PAIRS, 2, number of sensor pairs (≥1); lanes 2p and 2p+1 form pair p
- FAULT_LIMIT, 3, consecutive zero samples that latch a lane fault (≥1, ≤15)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- sensors  input  2*N_PAIRS*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- in_valid  input  1  sample present on sensors
- in_ready  output  1  block accepts a sample
- fault_clr  input  1  synchronous clear of all lane faults and zero counters
- height  output  WIDTH  rounded average height
- pairs_used  output  $clog2(N_PAIRS+1)  number of pairs included in height
- out_valid  output  1  height/pairs_used valid
- out_ready  input  1  consumer accepts result
- lane_fault  output  2*N_PAIRS  sticky per-lane fault flags

## Operation
- States: IDLE, ACCUM, DIVIDE, DONE. in_ready = 1 only in IDLE.
- IDLE: in_valid & in_ready → snapshot sensors into internal register, update zero counters, go ACCUM.
- Zero counters (4 bits/lane), at accept: lane==0 → counter+1 (saturating at FAULT_LIMIT), else counter=0. Counter reaching FAULT_LIMIT sets lane_fault bit; bit stays set even when lane becomes nonzero, until fault_clr or reset.
- fault_clr: clears counters and lane_fault; if coincident with accept, clear applies first, then the sample's update.
- Pair p qualifies iff both lanes nonzero and neither lane_fault bit set (after this sample's update).
- ACCUM: one pair per cycle, p = 0..N_PAIRS-1; qualifying pair adds both lanes to sum and increments pair count k.
- Sum width SUMW = WIDTH + $clog2(2*N_PAIRS); dividend = sum + k, divisor = 2k. Result = (sum+k)/(2k), round-half-up; always fits WIDTH.
- DIVIDE: restoring divider, one quotient bit per cycle, SUMW cycles. k == 0: divider still runs for fixed latency, result forced to 0.
- DONE: out_valid = 1; height, pairs_used held stable until out_ready; out_valid & out_ready → IDLE.
- Reset values: height 0, pairs_used 0, out_valid 0, lane_fault 0, in_ready 1 (IDLE), counters 0.

## Timing
- Accept edge E0. ACCUM on E1..E(N_PAIRS); DIVIDE on E(N_PAIRS+1)..E(N_PAIRS+SUMW); out_valid high after E(N_PAIRS+SUMW). Defaults: 12 cycles.
- Latency fixed, independent of data and k.
- lane_fault updates on the accept edge itself.
- Output handshake completes on the edge where out_valid & out_ready; in_ready high on the following cycle; no back-to-back accept in the same cycle as handshake. Throughput: one sample per N_PAIRS+SUMW+2 cycles at best.
- out_ready low: DONE holds indefinitely; sensors/in_valid ignored.
- in_valid changes outside IDLE are ignored; no sample queued.
- rst_n low at any point (including mid-ACCUM/DIVIDE): immediate return to IDLE, all outputs to reset values, partial result discarded.

## Test plan
- Defaults; lanes 100,102,98,101 → after 12 cycles out_valid, height 100 ((401+2)/4), pairs_used 2.
- Lanes 80,0,50,51 → pair 0 excluded; height 51 ((101+1)/2), pairs_used 1; lane_fault stays 0.
- All lanes 0 → height 0, pairs_used 0, out_valid at cycle 12; all lanes 255 → height 255 (no overflow).
- Lane 3 = 0 for three consecutive samples → lane_fault[3]=1 after third accept; fourth sample lanes 100,100,200,200 → height 100, pairs_used 1; pulse fault_clr, repeat → height 150, pairs_used 2.
- Hold out_ready low 5 cycles after out_valid → height/out_valid stable, in_ready 0, new in_valid ignored; raise out_ready → in_ready 1 next cycle.
- Assert rst_n low mid-DIVIDE → out_valid 0, in_ready 1, lane_fault 0 immediately; next sample 100,102,98,101 yields height 100 at normal latency.
